// File: rtl/am9513_exec_sched.sv
// Issue scheduler for the Am9513 shared EU: arbitrates legacy and CAI requests,
// decodes them, runs one op at a time and keeps per-context sticky IEEE flags.
module am9513_exec_sched #(
  parameter int         CTX_COUNT      = 4,
  parameter logic [7:0] LEG_FMT        = 8'h01,
  parameter logic [2:0] DEF_MODE       = 3'd2,
  parameter int         TIMEOUT_CYCLES = 1024,
  localparam int        CW             = $clog2(CTX_COUNT),
  localparam int        TW             = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          leg_req_valid,
  output logic          leg_req_ready,
  input  logic [7:0]    leg_req_op,
  input  logic [63:0]   leg_req_a,
  input  logic [63:0]   leg_req_b,
  input  logic [63:0]   leg_req_c,
  output logic          leg_rsp_valid,
  input  logic          leg_rsp_ready,
  output logic [63:0]   leg_rsp_data,
  output logic [4:0]    leg_rsp_flags,
  input  logic          cai_req_valid,
  output logic          cai_req_ready,
  input  logic [31:0]   cai_req_opcode,
  input  logic [31:0]   cai_req_flags,
  input  logic [CW-1:0] cai_req_ctx,
  input  logic [63:0]   cai_req_a,
  input  logic [63:0]   cai_req_b,
  input  logic [63:0]   cai_req_c,
  output logic          cai_rsp_valid,
  input  logic          cai_rsp_ready,
  output logic [63:0]   cai_rsp_data,
  output logic [4:0]    cai_rsp_flags,
  output logic          cai_rsp_err,
  output logic          eu_start,
  output logic          eu_abort,
  output logic [7:0]    eu_func,
  output logic [7:0]    eu_fmt,
  output logic [2:0]    eu_mode,
  output logic [63:0]   eu_a,
  output logic [63:0]   eu_b,
  output logic [63:0]   eu_c,
  input  logic          eu_done,
  input  logic [63:0]   eu_result,
  input  logic [4:0]    eu_flags,
  input  logic [CW-1:0] flag_ctx,
  input  logic          flag_clr,
  output logic [4:0]    flag_rd,
  output logic          busy,
  output logic [1:0]    dbg_state
);
  // Handshakes: a transfer occurs on the rising edge where valid && ready are both
  // high; a raised valid holds with stable payload until then. Request ready is
  // combinational on both request valids; response valid never waits on ready.
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  localparam logic [4:0] FLAG_NV = 5'b00001;

  state_t        state_q, state_d;
  logic          last_cai_q, own_leg_q;
  logic [CW-1:0] ctx_q;
  logic [TW-1:0] wait_cnt_q;
  logic [4:0]    sticky_q [CTX_COUNT];
  logic [4:0]    sticky_d [CTX_COUNT];
  logic          grant_leg, acc_leg, acc_cai, leg_ok, cai_ok, timeout, finish_op;
  logic          set_en;
  logic [4:0]    set_flags;
  logic [CW-1:0] set_ctx;
  logic [7:0]    leg_func;
  logic [2:0]    cai_mode;
  logic          unused_flags;

  function automatic logic [7:0] leg_map(input logic [7:0] op);
    case (op)
      8'h01:   leg_map = 8'h01;
      8'h02:   leg_map = 8'h03;
      8'h03:   leg_map = 8'h04;
      8'h04:   leg_map = 8'h05;
      8'h05:   leg_map = 8'h06;
      default: leg_map = 8'h00;
    endcase
  endfunction

  function automatic logic cai_func_defined(input logic [7:0] f);
    cai_func_defined = (f >= 8'h01 && f <= 8'h0A) || (f >= 8'h10 && f <= 8'h14) ||
                       (f >= 8'h20 && f <= 8'h27);
  endfunction

  assign unused_flags = ^cai_req_flags[31:4];
  assign leg_func     = leg_map(leg_req_op);
  assign leg_ok       = (leg_func != 8'h00);
  assign cai_mode     = cai_req_flags[0] ? cai_req_flags[3:1] : DEF_MODE;
  assign cai_ok       = cai_req_opcode[31] && (cai_req_opcode[30:16] == 15'h0) &&
                        cai_func_defined(cai_req_opcode[7:0]) &&
                        (!cai_req_flags[0] || (cai_req_flags[3:1] <= 3'd2));

  // last_cai_q set means CAI won the previous grant, so legacy wins a tie.
  assign grant_leg = leg_req_valid && (!cai_req_valid || last_cai_q);
  assign acc_leg   = leg_req_valid && leg_req_ready;
  assign acc_cai   = cai_req_valid && cai_req_ready;
  assign timeout   = (wait_cnt_q == TW'(TIMEOUT_CYCLES - 1));
  assign finish_op = (state_q == WAIT) && (eu_done || timeout);
  assign set_en    = finish_op || (acc_leg && !leg_ok);
  assign set_flags = ((state_q == WAIT) && eu_done) ? eu_flags : FLAG_NV;
  assign set_ctx   = finish_op ? ctx_q : '0;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;
  assign flag_rd   = sticky_q[flag_ctx];
  assign leg_rsp_valid = (state_q == RESP) && own_leg_q;
  assign cai_rsp_valid = (state_q == RESP) && !own_leg_q;

  always_comb begin
    state_d       = state_q;
    leg_req_ready = 1'b0;
    cai_req_ready = 1'b0;
    eu_start      = 1'b0;
    eu_abort      = 1'b0;
    case (state_q)
      IDLE: begin
        leg_req_ready = grant_leg;
        cai_req_ready = cai_req_valid && !grant_leg;
        if (grant_leg)          state_d = leg_ok ? ISSUE : RESP;
        else if (cai_req_valid) state_d = cai_ok ? ISSUE : RESP;
      end
      ISSUE: begin
        eu_start = 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        if (eu_done) begin
          state_d = RESP;
        end else if (timeout) begin
          eu_abort = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: if (own_leg_q ? leg_rsp_ready : cai_rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      last_cai_q    <= 1'b1;
      own_leg_q     <= 1'b0;
      ctx_q         <= '0;
      wait_cnt_q    <= '0;
      eu_func       <= '0;
      eu_fmt        <= '0;
      eu_mode       <= '0;
      eu_a          <= '0;
      eu_b          <= '0;
      eu_c          <= '0;
      leg_rsp_data  <= '0;
      leg_rsp_flags <= '0;
      cai_rsp_data  <= '0;
      cai_rsp_flags <= '0;
      cai_rsp_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (acc_leg || acc_cai) begin
        last_cai_q <= acc_cai;
        own_leg_q  <= acc_leg;
      end
      if (acc_leg) begin
        ctx_q <= '0;
        if (leg_ok) begin
          eu_func <= leg_func;
          eu_fmt  <= LEG_FMT;
          eu_mode <= 3'd0;
          eu_a    <= leg_req_a;
          eu_b    <= leg_req_b;
          eu_c    <= leg_req_c;
        end else begin
          leg_rsp_data  <= '0;
          leg_rsp_flags <= FLAG_NV;
        end
      end
      if (acc_cai) begin
        ctx_q <= cai_req_ctx;
        if (cai_ok) begin
          eu_func <= cai_req_opcode[7:0];
          eu_fmt  <= cai_req_opcode[15:8];
          eu_mode <= cai_mode;
          eu_a    <= cai_req_a;
          eu_b    <= cai_req_b;
          eu_c    <= cai_req_c;
        end else begin
          cai_rsp_data  <= '0;
          cai_rsp_flags <= '0;
          cai_rsp_err   <= 1'b1;
        end
      end
      if (state_q == ISSUE)     wait_cnt_q <= '0;
      else if (state_q == WAIT) wait_cnt_q <= wait_cnt_q + TW'(1);
      // A timeout is the only way to finish without eu_done.
      if (finish_op) begin
        if (own_leg_q) begin
          leg_rsp_data  <= eu_done ? eu_result : '0;
          leg_rsp_flags <= set_flags;
        end else begin
          cai_rsp_data  <= eu_done ? eu_result : '0;
          cai_rsp_flags <= set_flags;
          cai_rsp_err   <= !eu_done;
        end
      end
    end
  end

  // Clear applies before the OR so a same-cycle clear and set keeps the new flags.
  always_comb begin
    for (int i = 0; i < CTX_COUNT; i++) begin
      sticky_d[i] = sticky_q[i];
      if (flag_clr && (flag_ctx == CW'(i))) sticky_d[i] = 5'b0;
      if (set_en && (set_ctx == CW'(i)))    sticky_d[i] = sticky_d[i] | set_flags;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < CTX_COUNT; i++) begin
      if (rst) sticky_q[i] <= '0;
      else     sticky_q[i] <= sticky_d[i];
    end
  end
endmodule

// File: tb/tb_am9513_exec_sched.sv
// Randomized bench for am9513_exec_sched: an EU responder plus a reference model
// derived from the decode tables, latency rules and sticky-flag rules.
module tb_am9513_exec_sched;
  localparam int TO = 8;
  localparam int EW = 71;

  logic        clk = 1'b0;
  logic        rst;
  logic        leg_req_valid, leg_req_ready, leg_rsp_valid, leg_rsp_ready;
  logic [7:0]  leg_req_op;
  logic [63:0] leg_req_a, leg_req_b, leg_req_c, leg_rsp_data;
  logic [4:0]  leg_rsp_flags;
  logic        cai_req_valid, cai_req_ready, cai_rsp_valid, cai_rsp_ready, cai_rsp_err;
  logic [31:0] cai_req_opcode, cai_req_flags;
  logic [1:0]  cai_req_ctx;
  logic [63:0] cai_req_a, cai_req_b, cai_req_c, cai_rsp_data;
  logic [4:0]  cai_rsp_flags;
  logic        eu_start, eu_abort, eu_done;
  logic [7:0]  eu_func, eu_fmt;
  logic [2:0]  eu_mode;
  logic [63:0] eu_a, eu_b, eu_c, eu_result;
  logic [4:0]  eu_flags;
  logic [1:0]  flag_ctx;
  logic        flag_clr;
  logic [4:0]  flag_rd;
  logic        busy;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  am9513_exec_sched #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .leg_req_valid(leg_req_valid), .leg_req_ready(leg_req_ready), .leg_req_op(leg_req_op),
    .leg_req_a(leg_req_a), .leg_req_b(leg_req_b), .leg_req_c(leg_req_c),
    .leg_rsp_valid(leg_rsp_valid), .leg_rsp_ready(leg_rsp_ready),
    .leg_rsp_data(leg_rsp_data), .leg_rsp_flags(leg_rsp_flags),
    .cai_req_valid(cai_req_valid), .cai_req_ready(cai_req_ready),
    .cai_req_opcode(cai_req_opcode), .cai_req_flags(cai_req_flags), .cai_req_ctx(cai_req_ctx),
    .cai_req_a(cai_req_a), .cai_req_b(cai_req_b), .cai_req_c(cai_req_c),
    .cai_rsp_valid(cai_rsp_valid), .cai_rsp_ready(cai_rsp_ready),
    .cai_rsp_data(cai_rsp_data), .cai_rsp_flags(cai_rsp_flags), .cai_rsp_err(cai_rsp_err),
    .eu_start(eu_start), .eu_abort(eu_abort), .eu_func(eu_func), .eu_fmt(eu_fmt),
    .eu_mode(eu_mode), .eu_a(eu_a), .eu_b(eu_b), .eu_c(eu_c),
    .eu_done(eu_done), .eu_result(eu_result), .eu_flags(eu_flags),
    .flag_ctx(flag_ctx), .flag_clr(flag_clr), .flag_rd(flag_rd),
    .busy(busy), .dbg_state(dbg_state)
  );

  int total = 0;
  int bad = 0;
  logic [EW-1:0] exp_q[$];
  logic [4:0] sticky_m [4];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // Reference decode, taken from the op tables rather than the design.
  function automatic logic [7:0] ref_leg_func(input logic [7:0] op);
    logic [7:0] tbl [5] = '{8'h01, 8'h03, 8'h04, 8'h05, 8'h06};
    int idx;
    idx = int'(op) - 1;
    if (idx >= 0 && idx < 5) return tbl[idx];
    return 8'h00;
  endfunction

  function automatic bit ref_cai_legal(input logic [31:0] opc, input logic [31:0] fl);
    int f;
    f = int'(opc[7:0]);
    if (opc[31] != 1'b1 || opc[30:16] != 15'd0) return 1'b0;
    if (fl[0] && fl[3:1] > 3'd2) return 1'b0;
    return f inside {[1:10], [16:20], [32:39]};
  endfunction

  // EU responder: plan_lat == 0 means the EU never answers.
  int          plan_lat = 1;
  logic [63:0] plan_result = '0;
  logic [4:0]  plan_flags = '0;
  bit          plan_clr = 1'b0;
  int          st_cnt = 0;
  logic [7:0]  cap_func, cap_fmt;
  logic [2:0]  cap_mode;
  logic [63:0] cap_a, cap_b, cap_c;

  initial begin
    eu_done = 1'b0; eu_result = '0; eu_flags = '0; flag_clr = 1'b0;
    forever begin
      @(negedge clk);
      if (eu_start) begin
        st_cnt++;
        cap_func = eu_func; cap_fmt = eu_fmt; cap_mode = eu_mode;
        cap_a = eu_a; cap_b = eu_b; cap_c = eu_c;
        if (plan_lat > 0) begin
          repeat (plan_lat) @(negedge clk);
          eu_done = 1'b1; eu_result = plan_result; eu_flags = plan_flags; flag_clr = plan_clr;
          @(negedge clk);
          // Keep eu_done high one more cycle with junk: it lands in RESP and must be ignored.
          flag_clr = 1'b0; eu_result = ~plan_result; eu_flags = ~plan_flags;
          @(negedge clk);
          eu_done = 1'b0;
        end
      end
    end
  end

  int cyc = 0;
  int ab_cnt = 0;
  int ab_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (eu_abort) begin ab_cnt <= ab_cnt + 1; ab_cyc <= cyc; end

  task automatic check_all_sticky();
    for (int i = 0; i < 4; i++) begin
      flag_ctx = 2'(i);
      #1;
      check($sformatf("sticky%0d", i), flag_rd, sticky_m[i]);
    end
  endtask

  task automatic check_reset_outputs(input string p);
    check({p, "_busy"}, busy, 0);
    check({p, "_req_ready"}, {leg_req_ready, cai_req_ready}, 0);
    check({p, "_rsp_valid"}, {leg_rsp_valid, cai_rsp_valid}, 0);
    check({p, "_eu_pulses"}, {eu_start, eu_abort}, 0);
    check({p, "_eu_ctl"}, {eu_func, eu_fmt, eu_mode}, 0);
    check({p, "_eu_ops"}, eu_a | eu_b | eu_c, 0);
    check({p, "_rsp_bus"}, leg_rsp_data | cai_rsp_data, 0);
    check({p, "_rsp_flags"}, {leg_rsp_flags, cai_rsp_flags, cai_rsp_err}, 0);
    for (int i = 0; i < 4; i++) sticky_m[i] = 5'b0;
    check_all_sticky();
  endtask

  task automatic do_op(input bit leg, input logic [7:0] lop, input logic [31:0] opc,
                       input logic [31:0] fl, input logic [1:0] ctx, input int lat,
                       input int hold, input bit clr, input logic [1:0] clr_ctx, input int pf);
    logic [EW-1:0] want, got;
    logic [63:0] a, b, c, xdata;
    logic [7:0]  xf, xfmt;
    logic [2:0]  xm;
    logic [4:0]  xfl;
    logic [1:0]  xctx;
    bit legal, xerr;
    int n, start0, ab0, acc;
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; c = {$urandom, $urandom};
    plan_lat = lat;
    plan_result = {$urandom, $urandom};
    plan_flags = (pf < 0) ? 5'($urandom_range(0, 31)) : 5'(pf);
    if (leg) begin
      legal = (ref_leg_func(lop) != 8'h00);
      xf = ref_leg_func(lop); xfmt = 8'h01; xm = 3'd0; xctx = 2'd0;
    end else begin
      legal = ref_cai_legal(opc, fl);
      xf = opc[7:0]; xfmt = opc[15:8]; xm = fl[0] ? fl[3:1] : 3'd2; xctx = ctx;
    end
    plan_clr = clr && legal && (lat > 0);
    if (!legal)       begin xdata = '0; xfl = leg ? 5'b00001 : 5'b0; xerr = !leg; end
    else if (lat < 1) begin xdata = '0; xfl = 5'b00001; xerr = !leg; end
    else              begin xdata = plan_result; xfl = plan_flags; xerr = 1'b0; end
    exp_q.push_back({leg, xerr, xfl, xdata});
    @(negedge clk);
    flag_ctx = clr_ctx;
    if (leg) begin
      leg_req_valid = 1'b1; leg_req_op = lop; leg_req_a = a; leg_req_b = b; leg_req_c = c;
    end else begin
      cai_req_valid = 1'b1; cai_req_opcode = opc; cai_req_flags = fl; cai_req_ctx = ctx;
      cai_req_a = a; cai_req_b = b; cai_req_c = c;
    end
    #1;
    n = 0;
    while (!(leg ? leg_req_ready : cai_req_ready) && n < 20) begin @(negedge clk); n++; end
    check("req_ready", leg ? leg_req_ready : cai_req_ready, 1);
    start0 = st_cnt; ab0 = ab_cnt; acc = cyc;
    @(posedge clk); #1;
    leg_req_valid = 1'b0; cai_req_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end
    while (!(leg ? leg_rsp_valid : cai_rsp_valid) && n < 40);
    check("rsp_latency", n, !legal ? 1 : (lat < 1 ? TO + 2 : lat + 2));
    check("other_rsp_idle", leg ? cai_rsp_valid : leg_rsp_valid, 0);
    check("busy_in_resp", busy, 1);
    got  = {leg, leg ? 1'b0 : cai_rsp_err, leg ? leg_rsp_flags : cai_rsp_flags,
            leg ? leg_rsp_data : cai_rsp_data};
    want = exp_q.pop_front();
    check("rsp_data", got[63:0], want[63:0]);
    check("rsp_flags_err", got[70:64], want[70:64]);
    check("eu_start_count", st_cnt - start0, legal);
    check("abort_count", ab_cnt - ab0, legal && lat < 1);
    if (legal) begin
      check("eu_ctl_at_start", {cap_func, cap_fmt, cap_mode}, {xf, xfmt, xm});
      check("eu_ops_at_start", {cap_a ^ a, cap_b ^ b, cap_c ^ c}, 0);
      check("eu_ctl_held", {eu_func, eu_fmt, eu_mode, eu_a}, {xf, xfmt, xm, a});
      if (lat < 1) check("abort_cycle", ab_cyc - acc, TO + 1);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", leg ? leg_rsp_valid : cai_rsp_valid, 1);
      check("hold_data", leg ? leg_rsp_data : cai_rsp_data, want[63:0]);
    end
    check("no_b2b", {leg_req_ready, cai_req_ready}, 0);
    if (leg) leg_rsp_ready = 1'b1; else cai_rsp_ready = 1'b1;
    @(negedge clk);
    leg_rsp_ready = 1'b0; cai_rsp_ready = 1'b0;
    check("rsp_dropped", {leg_rsp_valid, cai_rsp_valid, busy}, 0);
    if (leg || legal) begin
      if (plan_clr) sticky_m[clr_ctx] = 5'b0;
      sticky_m[xctx] = sticky_m[xctx] | xfl;
    end
    check_all_sticky();
  endtask

  bit gl, rl;
  int n, ab_base, lat;
  logic [7:0] lop, fn;
  logic [31:0] opc, fl;

  initial begin
    rst = 1'b1;
    leg_req_valid = 0; leg_req_op = 0; leg_req_a = 0; leg_req_b = 0; leg_req_c = 0;
    leg_rsp_ready = 0; cai_req_valid = 0; cai_req_opcode = 0; cai_req_flags = 0;
    cai_req_ctx = 0; cai_req_a = 0; cai_req_b = 0; cai_req_c = 0; cai_rsp_ready = 0;
    flag_ctx = 0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    do_op(1, 8'h01, 0, 0, 0, 4, 0, 0, 0, 5'b10000);
    do_op(0, 0, 32'h8000_0206, 32'h3, 2'd2, 3, 0, 0, 0, -1);

    // Both requesters valid continuously: grants must alternate starting with legacy.
    @(negedge clk);
    leg_req_valid = 1; leg_req_op = 8'h02;
    cai_req_valid = 1; cai_req_opcode = 32'h8000_0101; cai_req_flags = 0; cai_req_ctx = 2'd3;
    #1;
    for (int k = 0; k < 4; k++) begin
      plan_lat = $urandom_range(1, 4); plan_clr = 0;
      plan_result = {$urandom, $urandom}; plan_flags = 5'($urandom_range(0, 31));
      n = 0;
      while (!(leg_req_ready || cai_req_ready) && n < 20) begin @(negedge clk); n++; end
      gl = leg_req_ready;
      check("tie_grant", gl, (k % 2) == 0);
      @(posedge clk); #1;
      if (k == 3) begin leg_req_valid = 0; cai_req_valid = 0; end
      n = 0;
      do begin @(negedge clk); n++; end while (!(gl ? leg_rsp_valid : cai_rsp_valid) && n < 40);
      check("tie_rsp_data", gl ? leg_rsp_data : cai_rsp_data, plan_result);
      check("tie_no_b2b", {leg_req_ready, cai_req_ready}, 0);
      if (gl) sticky_m[0] = sticky_m[0] | plan_flags;
      else    sticky_m[3] = sticky_m[3] | plan_flags;
      if (gl) leg_rsp_ready = 1; else cai_rsp_ready = 1;
      @(negedge clk);
      leg_rsp_ready = 0; cai_rsp_ready = 0;
    end
    check_all_sticky();

    do_op(0, 0, 32'h0000_0201, 0, 2'd1, 2, 0, 0, 0, -1);
    do_op(1, 8'h07, 0, 0, 0, 2, 0, 0, 0, -1);
    do_op(0, 0, 32'h8000_0203, 32'h1, 2'd1, 0, 0, 0, 0, -1);
    do_op(0, 0, 32'h8000_0101, 32'h0, 2'd1, 2, 0, 0, 0, 5'b10010);
    do_op(0, 0, 32'h8000_0102, 32'h0, 2'd1, 3, 0, 1, 2'd1, 5'b00100);
    do_op(1, 8'h03, 0, 0, 0, 5, 5, 0, 0, -1);

    for (int t = 0; t < 36; t++) begin
      rl  = 1'($urandom_range(0, 1));
      lop = 8'($urandom_range(0, 7));
      fn  = 8'($urandom_range(0, 47));
      opc = {1'b1, 15'h0, 8'($urandom_range(0, 255)), fn};
      if ($urandom_range(0, 7) == 0) opc[31] = 1'b0;
      if ($urandom_range(0, 7) == 0) opc[16 + $urandom_range(0, 14)] = 1'b1;
      fl  = {28'h0, 3'($urandom_range(0, 3)), 1'($urandom_range(0, 1))};
      lat = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
      do_op(rl, lop, opc, fl, 2'($urandom_range(0, 3)), lat, $urandom_range(0, 3),
            1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), -1);
    end

    // Reset while the op waits on an EU that never answers.
    plan_lat = 0; plan_clr = 0;
    @(negedge clk);
    cai_req_valid = 1; cai_req_opcode = 32'h8000_0103; cai_req_flags = 0; cai_req_ctx = 2'd1;
    #1;
    n = 0;
    while (!cai_req_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    cai_req_valid = 0;
    repeat (4) @(negedge clk);
    check("mid_busy", busy, 1);
    ab_base = ab_cnt;
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("mid_no_abort", ab_cnt - ab_base, 0);
    check("mid_idle", {busy, cai_rsp_valid}, 0);
    do_op(1, 8'h05, 0, 0, 0, 2, 1, 0, 0, -1);
    do_op(0, 0, 32'h8000_0425, 32'h5, 2'd3, 1, 0, 0, 0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
